// File: rtl/dmem_seq_reader.sv
// Sequential block reader for dmem port 1 (Sequence Mode). Issues one read
// per cycle while the output FIFO has room and streams the words out over valid/ready.
module dmem_seq_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 128,
    parameter int LEN_W      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              MEM_MODE,
    output logic              MEM_WEB1,
    output logic              MEM_OEB1,
    output logic [ADDR_W-1:0] MEM_A1,
    input  logic [DATA_W-1:0] MEM_SEQ_O1,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_LAST
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [LEN_W-1:0]   rem_r;
    logic               inflight_r;
    logic               inflight_last_r;
    logic [DATA_W-1:0]  data_r [FIFO_DEPTH];
    logic               last_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   occ_s;
    logic               start_ok_s;
    logic               issue_s;
    logic               issue_last_s;
    logic               push_s;
    logic               pop_s;

    // Issue decision: a read in flight counts as an occupied slot so a push never overflows.
    always_comb begin
        occ_s        = count_r + CNT_W'(inflight_r);
        start_ok_s   = (state_r == ST_IDLE) && START;
        issue_s      = (state_r == ST_ISSUE) && (occ_s < CNT_W'(FIFO_DEPTH));
        issue_last_s = issue_s && (rem_r == LEN_W'(1));
        push_s       = inflight_r;
        pop_s        = OUT_VALID && OUT_READY;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_nxt_s = (LEN == LEN_W'(0)) ? ST_FIN : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (pop_s && OUT_LAST) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, address/length counters and the one-deep read pipeline.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r         <= ST_IDLE;
            addr_r          <= '0;
            rem_r           <= '0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            inflight_r      <= issue_s;
            inflight_last_r <= issue_last_s;
            if (start_ok_s) begin
                addr_r <= BASE_ADDR;
                rem_r  <= LEN;
            end else if (issue_s) begin
                addr_r <= addr_r + ADDR_W'(1);
                rem_r  <= rem_r - LEN_W'(1);
            end
        end
    end

    // Output FIFO: data sampled one cycle after its address is presented.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_r[i] <= '0;
                last_r[i] <= 1'b0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                data_r[wr_ptr_r] <= MEM_SEQ_O1;
                last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Outputs decoded straight from registers.
    always_comb begin
        BUSY      = (state_r != ST_IDLE);
        DONE      = (state_r == ST_FIN);
        MEM_MODE  = BUSY;
        MEM_WEB1  = 1'b1;
        MEM_OEB1  = !issue_s;
        MEM_A1    = addr_r;
        OUT_VALID = (count_r != CNT_W'(0));
        if (OUT_VALID) begin
            OUT_DATA = data_r[rd_ptr_r];
            OUT_LAST = last_r[rd_ptr_r];
        end else begin
            OUT_DATA = '0;
            OUT_LAST = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_seq_reader.sv
// Directed bench for dmem_seq_reader with a one-cycle-latency memory model
// whose word at address k holds the value k.
module tb_dmem_seq_reader;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [7:0]   BASE_ADDR = 8'd0;
    logic [8:0]   LEN = 9'd0;
    logic         BUSY, DONE, MEM_MODE, MEM_WEB1, MEM_OEB1;
    logic [7:0]   MEM_A1;
    logic [127:0] MEM_SEQ_O1 = 128'd0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b1;
    logic [127:0] OUT_DATA;
    logic         OUT_LAST;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_valid = -1;
    int valid_cnt = 0;
    int issue_a[$];
    int issue_c[$];
    int pop_d[$];
    int pop_l[$];
    int pop_c[$];
    int done_c[$];

    dmem_seq_reader dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .MEM_MODE(MEM_MODE), .MEM_WEB1(MEM_WEB1),
        .MEM_OEB1(MEM_OEB1), .MEM_A1(MEM_A1), .MEM_SEQ_O1(MEM_SEQ_O1),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_LAST(OUT_LAST)
    );

    always #5 CLK = ~CLK;

    // Memory model: address presented in cycle t appears on SEQ_O1 during t+1.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!MEM_OEB1) MEM_SEQ_O1 <= {120'd0, MEM_A1};
    end

    // Event logger sampling on the falling edge.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (!MEM_OEB1) begin
                issue_a.push_back(int'(MEM_A1));
                issue_c.push_back(cyc);
            end
            if (OUT_VALID) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (OUT_VALID && OUT_READY) begin
                pop_d.push_back(int'(OUT_DATA[31:0]) | ((OUT_DATA[127:32] != 96'd0) ? 32'h8000_0000 : 32'd0));
                pop_l.push_back(int'(OUT_LAST));
                pop_c.push_back(cyc);
            end
            if (DONE) done_c.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        issue_a.delete(); issue_c.delete();
        pop_d.delete(); pop_l.delete(); pop_c.delete(); done_c.delete();
        first_valid = -1;
        valid_cnt = 0;
    endtask

    // Called on a falling edge; START is held for exactly one rising edge.
    task automatic start_xfer(input logic [7:0] b, input logic [8:0] l);
        START = 1'b1; BASE_ADDR = b; LEN = l; start_cyc = cyc;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 200;
        while (done_c.size() == 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (budget == 0) check_val({tag, "_timeout"}, 128'd0, 128'd1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        check_val({tag, "_npop"}, pop_d.size(), n);
        for (int i = 0; i < n && i < pop_d.size(); i++) begin
            check_val({tag, "_data"}, pop_d[i], (base + i) % 256);
            check_val({tag, "_last"}, pop_l[i], (i == n - 1) ? 1 : 0);
        end
        check_val({tag, "_ndone"}, done_c.size(), 1);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check_val("rst_busy", BUSY, 1'b0);
        check_val("rst_oeb1", MEM_OEB1, 1'b1);
        check_val("rst_a1", MEM_A1, 8'd0);
        check_val("rst_valid", OUT_VALID, 1'b0);
        RST_N = 1'b1;
        @(negedge CLK);
        check_val("idle_web1", MEM_WEB1, 1'b1);
        check_val("idle_mode", MEM_MODE, 1'b0);

        // Basic 4-word transfer at 0x10
        clear_log();
        start_xfer(8'h10, 9'd4);
        check_val("t1_busy", BUSY, 1'b1);
        check_val("t1_mode", MEM_MODE, 1'b1);
        wait_done("t1");
        check_val("t1_nissue", issue_a.size(), 4);
        for (int i = 0; i < 4 && i < issue_a.size(); i++) begin
            check_val("t1_addr", issue_a[i], 16 + i);
            check_val("t1_icyc", issue_c[i], start_cyc + 1 + i);
        end
        check_val("t1_first_valid", first_valid, start_cyc + 3);
        check_stream("t1", 16, 4);
        if (pop_c.size() == 4 && done_c.size() > 0)
            check_val("t1_done_cyc", done_c[0], pop_c[3] + 1);
        check_val("t1_busy_after", BUSY, 1'b0);

        // Backpressure: only FIFO_DEPTH reads before the stall
        clear_log();
        OUT_READY = 1'b0;
        start_xfer(8'h40, 9'd8);
        repeat (9) @(negedge CLK);
        check_val("t2_stall_issues", issue_a.size(), 4);
        check_val("t2_stall_oeb1", MEM_OEB1, 1'b1);
        check_val("t2_hold_data", OUT_DATA, 128'h40);
        OUT_READY = 1'b1;
        wait_done("t2");
        check_val("t2_nissue", issue_a.size(), 8);
        check_stream("t2", 64, 8);

        // Address wrap
        clear_log();
        start_xfer(8'hFE, 9'd3);
        wait_done("t3");
        check_val("t3_nissue", issue_a.size(), 3);
        for (int i = 0; i < 3 && i < issue_a.size(); i++)
            check_val("t3_addr", issue_a[i], (254 + i) % 256);
        check_stream("t3", 254, 3);

        // Zero-length transfer
        clear_log();
        start_xfer(8'h33, 9'd0);
        wait_done("t4");
        check_val("t4_nissue", issue_a.size(), 0);
        check_val("t4_valid", valid_cnt, 0);
        if (done_c.size() > 0) check_val("t4_done_cyc", done_c[0], start_cyc + 1);
        check_val("t4_ndone", done_c.size(), 1);

        // Reset mid-transfer, then a clean transfer
        clear_log();
        start_xfer(8'h20, 9'd6);
        for (int k = 0; k < 50 && issue_a.size() < 2; k++) @(negedge CLK);
        check_val("t5_two_issued", issue_a.size(), 2);
        RST_N = 1'b0;
        #1;
        check_val("t5_busy", BUSY, 1'b0);
        check_val("t5_done", DONE, 1'b0);
        check_val("t5_mode", MEM_MODE, 1'b0);
        check_val("t5_oeb1", MEM_OEB1, 1'b1);
        check_val("t5_a1", MEM_A1, 8'd0);
        check_val("t5_valid", OUT_VALID, 1'b0);
        check_val("t5_data", OUT_DATA, 128'd0);
        check_val("t5_last", OUT_LAST, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        clear_log();
        start_xfer(8'h30, 9'd2);
        wait_done("t5b");
        check_stream("t5b", 48, 2);

        // START while busy is ignored
        clear_log();
        start_xfer(8'h50, 9'd4);
        @(negedge CLK);
        start_xfer(8'h90, 9'd2);
        wait_done("t6");
        check_val("t6_nissue", issue_a.size(), 4);
        for (int i = 0; i < 4 && i < issue_a.size(); i++)
            check_val("t6_addr", issue_a[i], 80 + i);
        check_stream("t6", 80, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_seq_reader.md
Name: dmem_seq_reader

Overview:
- Streams a contiguous block of words out of dmem port 1 in Sequence Mode and feeds the FFT datapath over a valid/ready interface.
- Sits directly downstream of dmem: drives MODE, CE1-side control (WEB1, OEB1, A1) and consumes SEQ_O1.
- Each read is issued one cycle before its data is used. A small output FIFO absorbs backpressure so no read is ever lost.

Parameters:
- ADDR_W, 8, dmem word address width (matches DM_ADDR)
- DATA_W, 128, sequence data width (matches DM_ARRAY_COLS)
- LEN_W, 9, width of transfer length; max length 2^LEN_W-1
- FIFO_DEPTH, 4, output buffer entries; power of two, >=2

Ports:
- CLK  in  1  block clock; also drives dmem CE1
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse; latch BASE_ADDR/LEN, begin transfer
- BASE_ADDR  in  ADDR_W  first word address
- LEN  in  LEN_W  number of words to read
- BUSY  out  1  high from accepted START until DONE cycle inclusive
- DONE  out  1  one-cycle pulse after last word handed off
- MEM_MODE  out  1  to dmem MODE; 1 while BUSY, else 0
- MEM_WEB1  out  1  to dmem WEB1; constant 1 (read only)
- MEM_OEB1  out  1  to dmem OEB1; 0 in cycles a read is issued, else 1
- MEM_A1  out  ADDR_W  to dmem A1
- MEM_SEQ_O1  in  DATA_W  from dmem SEQ_O1
- OUT_VALID  out  1  FIFO head valid
- OUT_READY  in  1  consumer accepts head when OUT_VALID&OUT_READY
- OUT_DATA  out  DATA_W  FIFO head data
- OUT_LAST  out  1  head is final word of transfer

Behaviour:
- Reset (async, RST_N low): state IDLE; BUSY=0, DONE=0, MEM_MODE=0, MEM_OEB1=1, MEM_A1=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0; FIFO empty; counters 0. Reset mid-transfer discards in-flight and buffered data. No DONE is produced.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - START with LEN>0: latch address and length, go to ISSUE next cycle, BUSY=1.
  - START with LEN=0: go to FIN. No reads; DONE pulses the cycle after START.
- START while BUSY: ignored.
- ISSUE:
  - A read is issued in a cycle when (fifo_count + inflight) < FIFO_DEPTH, where inflight is 0 or 1.
  - On issue: MEM_OEB1=0, MEM_A1=current address. Address then increments modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0. Remaining count decrements.
  - Issuing the final word moves to DRAIN.
- Read latency: data for an address presented in cycle t is sampled from MEM_SEQ_O1 at the end of cycle t+1 and pushed into the FIFO. OUT_VALID rises in cycle t+2 at the earliest.
- OUT_LAST is set on the FIFO entry of the final word only.
- FIFO:
  - Simultaneous push and pop when full is legal, because a pop frees a slot. The issue condition guarantees a push never overflows.
  - Pop only on OUT_VALID&OUT_READY.
  - OUT_DATA and OUT_LAST hold stable while OUT_VALID&!OUT_READY.
- DRAIN: wait until the last entry is popped, then go to FIN.
- FIN: DONE=1 for exactly one cycle, BUSY=1 in that cycle, then IDLE.
- MEM_MODE is held 1 from the ISSUE entry cycle through the last data sample. This covers dmem's registered MODE.
- With OUT_READY held high, throughput is 1 word/cycle.

Test Plan:
- BASE_ADDR=0x10, LEN=4, OUT_READY=1, memory word k = k:
  - MEM_A1 = 0x10,0x11,0x12,0x13 on consecutive cycles.
  - OUT_DATA = 0x10..0x13, first OUT_VALID 2 cycles after first issue.
  - OUT_LAST on 0x13; DONE 1 cycle after that handoff.
- LEN=8, OUT_READY=0 for 10 cycles then 1:
  - Exactly FIFO_DEPTH=4 reads issued then stall (MEM_OEB1=1).
  - All 8 words delivered in order, no duplicates or losses.
- BASE_ADDR=0xFE, LEN=3: MEM_A1 = 0xFE, 0xFF, 0x00; data 0xFE, 0xFF, 0x00.
- START with LEN=0: no MEM_OEB1 low; DONE pulses next cycle; OUT_VALID never asserts.
- RST_N low after 2 issued reads of LEN=6: all outputs return to reset values immediately. A subsequent START with LEN=2 completes normally with no stale data.
- START pulsed again mid-transfer with different BASE_ADDR: ignored; original transfer completes unchanged.
